// File: rtl/period_meter_pkg.sv
// Shared types and default parameters for the period meter and its
// synchroniser front end.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_e;

    localparam int CNT_W_DEF       = 32;
    localparam int TIMEOUT_CYC_DEF = 50000000;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/period_meter_sync_rise.sv
// Synchroniser chain for an asynchronous level plus one edge register;
// rise pulses for one clk when the synchronised level goes 0 -> 1.
module sync_rise_detect
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_dly_q, lvl_dly_d;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
        lvl_dly_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            lvl_dly_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            lvl_dly_q <= lvl_dly_d;
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_dly_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles,
// with valid/ack handshake, overrun flag and loss-of-signal timeout.
//
// state | meaning
// IDLE  | disabled, counters held at 0
// ARM   | waiting for the first rising edge (no reference yet)
// MEAS  | counting between successive rising edges
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  logic             meas_ack,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overrun,
    output logic             no_signal
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("period_meter: SYNC_STAGES must be >= 2");
    end
    if (64'(TIMEOUT_CYC) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
        $error("period_meter: TIMEOUT_CYC does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic lvl, rise;

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .lvl    (lvl),
        .rise   (rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, idle_q, idle_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic             valid_q, valid_d, overrun_q, overrun_d, no_sig_q, no_sig_d;
    logic             load, timeout_hit;

    assign load        = (state_q == MEAS) && rise;
    assign timeout_hit = ((idle_q + ONE) == TIMEOUT_V);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        idle_d    = idle_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        no_sig_d  = no_sig_q;

        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hcnt_d    = '0;
            idle_d    = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
            no_sig_d  = 1'b0;
        end else begin
            if (meas_ack && valid_q && !load) begin
                valid_d   = 1'b0;
                overrun_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    idle_d  = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d    = ONE;
                        hcnt_d   = ONE;
                        idle_d   = '0;
                        no_sig_d = 1'b0;
                        state_d  = MEAS;
                    end else if (timeout_hit) begin
                        idle_d   = '0;
                        no_sig_d = 1'b1;
                    end else begin
                        idle_d = idle_q + ONE;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        // the rise cycle itself starts the next period
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        valid_d   = 1'b1;
                        overrun_d = valid_q & ~meas_ack;
                        cnt_d     = ONE;
                        hcnt_d    = ONE;
                        idle_d    = '0;
                        no_sig_d  = 1'b0;
                    end else if (timeout_hit) begin
                        cnt_d    = '0;
                        hcnt_d   = '0;
                        idle_d   = '0;
                        no_sig_d = 1'b1;
                        state_d  = ARM;
                    end else begin
                        cnt_d  = cnt_q + ONE;
                        hcnt_d = hcnt_q + CNT_W'(lvl);
                        idle_d = idle_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            idle_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            no_sig_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            idle_q    <= idle_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            no_sig_q  <= no_sig_d;
        end
    end

    assign meas_valid = valid_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign overrun    = overrun_q;
    assign no_signal  = no_sig_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square-wave generator, handshake,
// overrun, timeout, reset/enable and fastest-period cases.
module tb_period_meter;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             sig_in = 1'b0;
    logic             meas_ack = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             overrun;
    logic             no_signal;

    int n_cmp = 0;
    int n_err = 0;

    bit gen_on = 1'b0;
    int gen_per = 10;
    int gen_high = 4;
    int ph = 0;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .meas_ack   (meas_ack),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .overrun    (overrun),
        .no_signal  (no_signal)
    );

    always #5 clk = ~clk;

    // square-wave source; only drives sig_in while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gen_on) begin
                sig_in = (ph < gen_high);
                ph = (ph + 1 >= gen_per) ? 0 : ph + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!meas_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!meas_valid) check(tag, 32'(meas_valid), 32'd1);
    endtask

    task automatic ack_pulse();
        meas_ack = 1'b1;
        @(negedge clk);
        meas_ack = 1'b0;
    endtask

    task automatic restart(input int per, input int hi);
        en = 1'b0;
        meas_ack = 1'b0;
        gen_per = per;
        gen_high = hi;
        ph = 0;
        gen_on = 1'b1;
        repeat (6) @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        int n;

        // reset state
        repeat (10) @(negedge clk);
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_period", period, 32'd0);
        check("rst_high", high_time, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_no_signal", 32'(no_signal), 32'd0);
        rst = 1'b1;

        // T1 basic, period 10 / high 4, ack every measurement
        restart(10, 4);
        for (int i = 0; i < 4; i++) begin
            wait_valid("t1_valid", 40);
            if (i > 0) begin
                check("t1_period", period, 32'd10);
                check("t1_high", high_time, 32'd4);
                check("t1_overrun", 32'(overrun), 32'd0);
            end
            ack_pulse();
        end

        // T2 divider-like odd count: full count 9, high 4
        restart(9, 4);
        wait_valid("t2_valid", 40);
        ack_pulse();
        wait_valid("t2_valid", 40);
        check("t2_period", period, 32'd9);
        check("t2_high", high_time, 32'd4);
        ack_pulse();

        // T3 overrun, period 8 / high 3
        restart(8, 3);
        wait_valid("t3_valid", 40);
        repeat (16) @(negedge clk);
        check("t3_ovr_valid", 32'(meas_valid), 32'd1);
        check("t3_ovr_flag", 32'(overrun), 32'd1);
        check("t3_ovr_period", period, 32'd8);
        check("t3_ovr_high", high_time, 32'd3);
        ack_pulse();
        check("t3_ack_valid", 32'(meas_valid), 32'd0);
        check("t3_ack_overrun", 32'(overrun), 32'd0);
        wait_valid("t3_valid2", 20);
        repeat (8) @(negedge clk);
        check("t3_ovr2_flag", 32'(overrun), 32'd1);
        repeat (7) @(negedge clk);
        ack_pulse();
        check("t3_ackrise_valid", 32'(meas_valid), 32'd1);
        check("t3_ackrise_overrun", 32'(overrun), 32'd0);
        check("t3_ackrise_period", period, 32'd8);
        ack_pulse();

        // T4 timeout after two hand-driven edges (rise-to-rise 8)
        en = 1'b0;
        gen_on = 1'b0;
        sig_in = 1'b0;
        repeat (6) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        sig_in = 1'b1;
        for (int k = 1; k <= 53; k++) begin
            @(negedge clk);
            if (k == 4) sig_in = 1'b0;
            if (k == 52) check("t4_ns_early", 32'(no_signal), 32'd0);
            if (k == 53) check("t4_ns_set", 32'(no_signal), 32'd1);
        end
        check("t4_period_manual", period, 32'd8);
        ack_pulse();
        gen_per = 12;
        gen_high = 5;
        ph = 0;
        gen_on = 1'b1;
        n = 0;
        while (no_signal && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_ns_clear", 32'(no_signal), 32'd0);
        check("t4_first_rise_novalid", 32'(meas_valid), 32'd0);
        wait_valid("t4_valid", 40);
        check("t4_period", period, 32'd12);
        check("t4_high", high_time, 32'd5);
        check("t4_ns_after", 32'(no_signal), 32'd0);
        ack_pulse();

        // T5 async reset mid-period, then enable drop mid-MEAS
        restart(10, 4);
        wait_valid("t5_valid", 40);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(meas_valid), 32'd0);
        check("t5_rst_period", period, 32'd0);
        check("t5_rst_high", high_time, 32'd0);
        check("t5_rst_overrun", 32'(overrun), 32'd0);
        check("t5_rst_no_signal", 32'(no_signal), 32'd0);
        #2;
        rst = 1'b1;
        wait_valid("t5_valid2", 40);
        repeat (10) @(negedge clk);
        check("t5_ovr_flag", 32'(overrun), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("t5_en_valid", 32'(meas_valid), 32'd0);
        check("t5_en_overrun", 32'(overrun), 32'd0);
        check("t5_en_no_signal", 32'(no_signal), 32'd0);
        check("t5_en_period_held", period, 32'd10);
        restart(14, 6);
        wait_valid("t5_reen_valid", 60);
        check("t5_reen_period", period, 32'd14);
        check("t5_reen_high", high_time, 32'd6);
        ack_pulse();

        // T6 fastest measurable, period 2 / high 1
        restart(2, 1);
        wait_valid("t6_valid", 20);
        ack_pulse();
        for (int i = 0; i < 3; i++) begin
            wait_valid("t6_valid", 20);
            check("t6_period", period, 32'd2);
            check("t6_high", high_time, 32'd1);
            check("t6_overrun", 32'(overrun), 32'd0);
            ack_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
